// File: rtl/reload_dc_pkg.sv
// Shared types and default sizes for the reload down-counter.
// The wrap counter is built only when RELOAD_DC_WRAPCNT_EN is defined.
package reload_dc_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_WRAPW = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear; clear wins over inc.
// Used for the reload wrap count when RELOAD_DC_WRAPCNT_EN is defined.
module sat_counter #(
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WRAPW-1:0] count
);

  logic [WRAPW-1:0] count_q;
  logic [WRAPW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WRAPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/reload_down_counter.sv
// Presettable down-counter with one-shot / periodic reload and tc pulse.
// Define RELOAD_DC_WRAPCNT_EN to build the saturating wrap counter.
module reload_down_counter
  import reload_dc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WRAPW = DEF_WRAPW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy,
  output logic [WRAPW-1:0] wrap_count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      reload_d = preset;
      q_d      = preset;
      state_d  = (preset != '0) ? RUN : IDLE;
    end else if ((state_q == RUN) && enable) begin
      unique case (1'b1)
        (q_q > ONE): q_d = q_q - ONE;
        (q_q == ONE): begin
          q_d  = '0;
          tc_d = 1'b1;
        end
        default: begin
          // reload from the captured value, never live preset
          if (auto_reload) begin
            q_d = reload_q;
          end else begin
            state_d = DONE;
          end
        end
      endcase
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign Q    = q_q;
  assign tc   = tc_q;
  assign busy = busy_q;

`ifdef RELOAD_DC_WRAPCNT_EN
  logic wrap_inc;

  assign wrap_inc = !load && (state_q == RUN) && enable &&
                    (q_q == '0) && auto_reload;

  sat_counter #(
    .WRAPW(WRAPW)
  ) u_wrap (
    .clk  (clock),
    .rst  (reset),
    .clear(load),
    .inc  (wrap_inc),
    .count(wrap_count)
  );
`else
  assign wrap_count = '0;
`endif

endmodule
